// File: rtl/est_sync_dualrail_arbiter.sv
// Round-robin front-end feeding a dual-rail 2-bit async pipeline through a 4-phase
// return-to-zero handshake, with a synchronized ack and a stuck-pipeline timeout.
module est_sync_dualrail_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [1:0] data1,
    output logic       gnt1,
    output logic [3:0] dr_out,
    input  logic       ack_in,
    output logic       busy,
    output logic       last_id,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [3:0]             dr_q, dr_nxt;
    logic                   gnt0_q, gnt0_nxt;
    logic                   gnt1_q, gnt1_nxt;
    logic [1:0]             cap_q, cap_nxt;
    logic                   last_q, last_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;

    // Rails per bit are {t, f}; a zero bit raises the false rail.
    function automatic logic [3:0] encode(input logic [1:0] v);
        return {v[1], ~v[1], v[0], ~v[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dr_q   <= '0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            cap_q  <= '0;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            dr_q   <= dr_nxt;
            gnt0_q <= gnt0_nxt;
            gnt1_q <= gnt1_nxt;
            cap_q  <= cap_nxt;
            last_q <= last_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dr_nxt    = dr_q;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        cap_nxt   = cap_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                dr_nxt = '0;
                // On a tie the requester that did not win last time gets the slot.
                if (req1 && (!req0 || !last_q)) begin
                    gnt1_nxt  = 1'b1;
                    cap_nxt   = data1;
                    last_nxt  = 1'b1;
                    state_nxt = SEND;
                end else if (req0) begin
                    gnt0_nxt  = 1'b1;
                    cap_nxt   = data0;
                    last_nxt  = 1'b0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                dr_nxt    = encode(cap_q);
                cnt_nxt   = '0;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_s) begin
                    dr_nxt    = '0;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    dr_nxt    = '0;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    dr_nxt    = '0;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                dr_nxt = '0;
            end
            default: begin
                dr_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign dr_out  = dr_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign last_id = last_q;
    assign busy    = (state != IDLE);
    assign err     = (state == ERR);

endmodule

// File: tb/tb_est_sync_dualrail_arbiter.sv
// Directed and randomized checks for est_sync_dualrail_arbiter with a delayed-ack
// pipeline model; TIMEOUT is reduced to 8 so the stuck-pipeline case is quick.
module tb_est_sync_dualrail_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1;
    logic [3:0] dr_out;
    logic       ack_in = 1'b0;
    logic       busy, last_id, err;

    int checks = 0;
    int failures = 0;

    bit         ack_en = 1'b0;
    int         ack_dly = 3;
    logic [3:0] dr_seen = '0;
    int         ack_cd = 0;
    bit         pending = 1'b0;

    est_sync_dualrail_arbiter #(
        .SYNC_STAGES(2),
        .TIMEOUT(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .data0(data0),
        .gnt0(gnt0),
        .req1(req1),
        .data1(data1),
        .gnt1(gnt1),
        .dr_out(dr_out),
        .ack_in(ack_in),
        .busy(busy),
        .last_id(last_id),
        .err(err)
    );

    always #5 clk = ~clk;

    // Pipeline stage model: ack follows (dr_out != spacer) ack_dly cycles after each change.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!ack_en) begin
                ack_in  = 1'b0;
                dr_seen = dr_out;
                pending = 1'b0;
            end else begin
                if (dr_out != dr_seen) begin
                    dr_seen = dr_out;
                    ack_cd  = ack_dly;
                    pending = 1'b1;
                end
                if (pending) begin
                    if (ack_cd == 0) begin
                        ack_in  = (dr_seen != 4'b0000);
                        pending = 1'b0;
                    end else begin
                        ack_cd--;
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] code_of(input logic [1:0] v);
        case (v)
            2'b00:   return 4'b0101;
            2'b01:   return 4'b0110;
            2'b10:   return 4'b1001;
            default: return 4'b1010;
        endcase
    endfunction

    task automatic wait_gnt();
        int n = 0;
        while (!(gnt0 || gnt1) && n < 100) begin
            tick();
            n++;
        end
        check("gnt_wait", 32'(gnt0 | gnt1), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(busy), 0);
    endtask

    initial begin
        int n;
        int spur;
        logic exp_id;
        logic exp_valid;
        logic [3:0] exp_code;
        logic [3:0] prev_dr;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_dr", 32'(dr_out), 0);
        check("rst_gnt", 32'({gnt1, gnt0}), 0);
        check("rst_last", 32'(last_id), 1);

        // Single transfer, ack 3 cycles after each dr_out change
        ack_en = 1'b1;
        ack_dly = 3;
        req0 = 1'b1;
        data0 = 2'b10;
        tick();
        check("single_gnt0", 32'(gnt0), 1);
        check("single_gnt1", 32'(gnt1), 0);
        check("single_busy", 32'(busy), 1);
        check("single_last", 32'(last_id), 0);
        check("single_dr_send", 32'(dr_out), 0);
        req0 = 1'b0;
        tick();
        check("single_gnt_pulse", 32'(gnt0), 0);
        check("single_code", 32'(dr_out), 32'h9);
        n = 0;
        while (dr_out == 4'b1001 && n < 50) begin
            tick();
            n++;
        end
        check("single_hi_cycles", 32'(n), 6);
        check("single_spacer", 32'(dr_out), 0);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("single_lo_cycles", 32'(n), 6);
        check("single_idle", 32'(busy), 0);
        check("single_last_end", 32'(last_id), 0);

        // Hold-off: req1 raised during a requester-0 WAIT_HI
        req0 = 1'b1;
        data0 = 2'b00;
        tick();
        check("hold_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        tick();
        check("hold_code0", 32'(dr_out), 32'h5);
        req1 = 1'b1;
        data1 = 2'b11;
        spur = 0;
        n = 0;
        while (busy && n < 100) begin
            if (gnt1) spur++;
            tick();
            n++;
        end
        if (gnt1) spur++;
        check("hold_no_gnt1", 32'(spur), 0);
        tick();
        check("hold_gnt1", 32'(gnt1), 1);
        check("hold_gnt0_low", 32'(gnt0), 0);
        check("hold_last", 32'(last_id), 1);
        req1 = 1'b0;
        tick();
        check("hold_code1", 32'(dr_out), 32'hA);
        wait_idle();

        // Round-robin over 4 transfers with both requests held
        req0 = 1'b1;
        data0 = 2'b01;
        req1 = 1'b1;
        data1 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            wait_gnt();
            check("rr_gnt1", 32'(gnt1), 32'(exp_id));
            check("rr_gnt0", 32'(gnt0), 32'(!exp_id));
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            check("rr_code", 32'(dr_out), exp_id ? 32'hA : 32'h6);
            wait_idle();
        end

        // Reset while codeword 0101 is on the pipeline
        req0 = 1'b1;
        data0 = 2'b00;
        wait_gnt();
        req0 = 1'b0;
        tick();
        check("mid_code", 32'(dr_out), 32'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_dr", 32'(dr_out), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_err", 32'(err), 0);
        check("mid_last", 32'(last_id), 1);
        for (int i = 0; i < 6; i++) tick();
        req1 = 1'b1;
        data1 = 2'b01;
        tick();
        check("mid_fresh_gnt1", 32'(gnt1), 1);
        req1 = 1'b0;
        tick();
        check("mid_fresh_code", 32'(dr_out), 32'h6);
        wait_idle();
        check("mid_fresh_err", 32'(err), 0);

        // Timeout with ack stuck low
        ack_en = 1'b0;
        tick();
        req0 = 1'b1;
        data0 = 2'b10;
        wait_gnt();
        req0 = 1'b0;
        tick();
        check("to_code", 32'(dr_out), 32'h9);
        n = 0;
        while (!err && n < 50) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 8);
        check("to_dr", 32'(dr_out), 0);
        check("to_busy", 32'(busy), 1);
        req0 = 1'b1;
        req1 = 1'b1;
        spur = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt0 || gnt1) spur++;
        end
        check("to_no_gnt", 32'(spur), 0);
        check("to_err_sticky", 32'(err), 1);
        check("to_dr_hold", 32'(dr_out), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_rst_err", 32'(err), 0);
        check("to_rst_busy", 32'(busy), 0);

        // Random request / ack-delay sweep with invariant checks
        ack_en = 1'b1;
        exp_valid = 1'b0;
        exp_code = '0;
        prev_dr = dr_out;
        for (int c = 0; c < 3000; c++) begin
            if (!req0 && $urandom_range(3) == 0) begin
                req0 = 1'b1;
                data0 = 2'($urandom_range(3));
            end
            if (!req1 && $urandom_range(3) == 0) begin
                req1 = 1'b1;
                data1 = 2'($urandom_range(3));
            end
            if ($urandom_range(7) == 0) ack_dly = $urandom_range(3);
            tick();
            check("sw_rails", 32'((dr_out[3] & dr_out[2]) | (dr_out[1] & dr_out[0])), 0);
            check("sw_gnt_excl", 32'(gnt0 & gnt1), 0);
            if (exp_valid) begin
                check("sw_code", 32'(dr_out), 32'(exp_code));
                exp_valid = 1'b0;
            end else if (dr_out != prev_dr) begin
                check("sw_dr_step", 32'(dr_out), 0);
            end
            if (gnt0) begin
                exp_code = code_of(data0);
                exp_valid = 1'b1;
                req0 = 1'b0;
            end else if (gnt1) begin
                exp_code = code_of(data1);
                exp_valid = 1'b1;
                req1 = 1'b0;
            end
            prev_dr = dr_out;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        wait_idle();
        check("sw_err", 32'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
